// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage ahead of the decoder.
// Owns the PC, issues one memory request per instruction, latches the returned
// word and holds it for decode behind a valid/ready handshake. The commit-side
// verdict (branch redirect / halt) is sampled only on the accept cycle.
// Optional build macro: INST_FETCH_STALL_CNT_EN adds the o_stall_cnt port.
module inst_fetch #(
  parameter int INST_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_i_req,
  output logic [ADDR_W-1:0] o_i_addr,
  input  logic              i_i_valid,
  input  logic [INST_W-1:0] i_i_inst,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  input  logic              i_br_taken,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic              i_halt,
  output logic              o_done,
  output logic              o_err
`ifdef INST_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       o_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_seq;
  logic              accept;
  logic              tgt_misaligned;

  // o_inst_valid is only ever high in HOLD, so this is the commit point.
  assign accept         = o_inst_valid & i_inst_ready;
  assign tgt_misaligned = |i_br_target[1:0];
  // Sequential step wraps naturally mod 2^ADDR_W.
  assign pc_seq         = pc + ADDR_W'(PC_STEP);
  // The request address is the PC flop itself, so it can never diverge from it.
  assign o_i_addr       = pc;

  // Fetch FSM; all handshake outputs are registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      pc           <= '0;
      o_inst       <= '0;
      o_pc         <= '0;
      o_i_req      <= 1'b0;
      o_inst_valid <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_REQ;
          o_i_req <= 1'b1;
        end
        S_REQ: begin
          // Request is a single-cycle pulse.
          state   <= S_WAIT;
          o_i_req <= 1'b0;
        end
        S_WAIT: begin
          // Responses are only meaningful here; stale ones elsewhere are dropped.
          if (i_i_valid) begin
            state        <= S_HOLD;
            o_inst       <= i_i_inst;
            o_pc         <= pc;
            o_inst_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          // Branch/halt inputs are don't-care until the consumer accepts.
          if (accept) begin
            o_inst_valid <= 1'b0;
            if (i_halt) begin
              state  <= S_HALT;
              o_done <= 1'b1;
            end else if (i_br_taken && tgt_misaligned) begin
              state  <= S_HALT;
              o_done <= 1'b1;
              o_err  <= 1'b1;
            end else if (i_br_taken) begin
              state   <= S_REQ;
              pc      <= i_br_target;
              o_i_req <= 1'b1;
            end else begin
              state   <= S_REQ;
              pc      <= pc_seq;
              o_i_req <= 1'b1;
            end
          end
        end
        S_HALT: begin
          // Absorbing: only reset leaves.
          state <= S_HALT;
        end
        default: begin
          state        <= S_IDLE;
          o_i_req      <= 1'b0;
          o_inst_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef INST_FETCH_STALL_CNT_EN
  logic stall_cycle;

  // A stall is any cycle spent waiting on memory or on the consumer.
  assign stall_cycle = (state == S_WAIT) || ((state == S_HOLD) && !i_inst_ready);

  // Saturating stall counter; naturally frozen in HALT since neither term fires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_stall_cnt <= '0;
    else if (stall_cycle && (o_stall_cnt != 16'hFFFF))
      o_stall_cnt <= o_stall_cnt + 16'd1;
  end
`endif

endmodule
